multi_pulse_gen: RTL and testbench

- N-channel successor of the single-bit edge-to-pulse block, intended for pushbutton/switch front ends.
- Each channel runs a 2-FF synchroniser, then a debounce counter, then an edge detector. The edge detector is selectable per channel as rise, fall, both or off.
- Each detected edge produces a registered one-cycle pulse, and each channel also exports its debounced level.
- Sits between board I/O pins and the control FSMs that consume single-cycle strobes.

---
 rtl/multi_pulse_gen_pkg.sv | 31 +++
 rtl/multi_pulse_gen_pulse_chan.sv | 123 ++++++++++++
 rtl/multi_pulse_gen.sv | 34 +++
 tb/tb_multi_pulse_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulse_gen_pkg.sv
// Shared mode encodings, channel state type and pulse qualification helper
// for the multi-channel debounced edge-to-pulse block.
package multi_pulse_pkg;

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;
   localparam logic [1:0] MODE_OFF  = 2'b11;

   typedef enum logic [1:0] {
      LOW    = 2'b00,
      DEB_UP = 2'b01,
      HIGH   = 2'b10,
      DEB_DN = 2'b11
   } chan_state_t;

   // True when a flip in the given direction should produce a pulse.
   function automatic logic mode_hit(input logic [1:0] mode, input logic rising);
      case (mode)
         MODE_RISE: return rising;
         MODE_FALL: return !rising;
         MODE_BOTH: return 1'b1;
         default:   return 1'b0;
      endcase
   endfunction

   function automatic logic mode_repeats(input logic [1:0] mode);
      return (mode == MODE_RISE) || (mode == MODE_BOTH);
   endfunction

endpackage

// File: rtl/multi_pulse_gen_pulse_chan.sv
// One channel: 2-FF synchroniser, debounce FSM, edge qualification and
// optional auto-repeat (compiled in with MULTI_PULSE_AUTO_REPEAT_EN).
module pulse_chan
   import multi_pulse_pkg::*;
#(
   parameter int DEB_CYCLES    = 16,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_trig,
   input  logic [1:0] edge_mode,
   output logic       deb_level,
   output logic       out_pulse
);

   localparam int            CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          s1, s2;
   chan_state_t   state;
   logic [CW-1:0] cnt;
   logic          stable, cnt_done, flip, edge_hit, rep_hit;

   assign stable   = (state == HIGH) || (state == DEB_DN);
   assign cnt_done = (cnt == CNT_LAST);
   assign flip     = (s2 != stable) && cnt_done;
   // Direction is the opposite of the current stable level; mode is sampled now.
   assign edge_hit = flip && mode_hit(edge_mode, !stable);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= LOW;
         cnt       <= '0;
         deb_level <= 1'b0;
         out_pulse <= 1'b0;
      end else begin
         s1        <= in_trig;
         s2        <= s1;
         out_pulse <= edge_hit | rep_hit;
         case (state)
            LOW, DEB_UP: begin
               if (!s2) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state     <= HIGH;
                  cnt       <= '0;
                  deb_level <= 1'b1;
               end else begin
                  state <= DEB_UP;
                  cnt   <= cnt + 1'b1;
               end
            end
            HIGH, DEB_DN: begin
               if (s2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state     <= LOW;
                  cnt       <= '0;
                  deb_level <= 1'b0;
               end else begin
                  state <= DEB_DN;
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= LOW;
               cnt       <= '0;
               deb_level <= 1'b0;
            end
         endcase
      end
   end

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt, rep_target;
   logic          rep_first, rep_active, rep_mode_ok, rise_flip, fall_flip;

   assign rise_flip   = flip && !stable;
   assign fall_flip   = flip && stable;
   assign rep_mode_ok = mode_repeats(edge_mode);
   assign rep_target  = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
   // Fall flip or a non-repeating mode kills a repeat due on this very edge.
   assign rep_hit     = rep_active && rep_mode_ok && !fall_flip && (rep_cnt == rep_target);

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt    <= '0;
         rep_first  <= 1'b1;
         rep_active <= 1'b0;
      end else if (rise_flip) begin
         rep_cnt    <= '0;
         rep_first  <= 1'b1;
         rep_active <= rep_mode_ok;
      end else if (!rep_mode_ok || fall_flip) begin
         rep_cnt    <= '0;
         rep_first  <= 1'b1;
         rep_active <= 1'b0;
      end else if (rep_active) begin
         if (rep_cnt == rep_target) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   assign rep_hit = 1'b0;
   // Repeat timing only matters when auto-repeat is compiled in.
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_rep_cfg_unused
   end
`endif

endmodule

// File: rtl/multi_pulse_gen.sv
// N independent debounced edge-to-pulse channels for pushbutton/switch inputs.
// Optional auto-repeat on held inputs: define MULTI_PULSE_AUTO_REPEAT_EN.
module multi_pulse_gen
   import multi_pulse_pkg::*;
#(
   parameter int N             = 4,
   parameter int DEB_CYCLES    = 16,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 200
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_trig,
   input  logic [2*N-1:0] edge_mode,
   output logic [N-1:0]   deb_level,
   output logic [N-1:0]   out_pulse
);

   for (genvar i = 0; i < N; i++) begin : g_chan
      pulse_chan #(
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .in_trig  (in_trig[i]),
         .edge_mode(edge_mode[2*i+1:2*i]),
         .deb_level(deb_level[i]),
         .out_pulse(out_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Self-checking bench for multi_pulse_gen: directed scenarios plus random
// stimulus, all compared against a history-window reference model.
module tb_multi_pulse_gen;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_trig;
   logic [2*N-1:0] edge_mode;
   logic [N-1:0]   deb_level;
   logic [N-1:0]   out_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_pulse_gen #(
      .N            (N),
      .DEB_CYCLES   (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_trig  (in_trig),
      .edge_mode(edge_mode),
      .deb_level(deb_level),
      .out_pulse(out_pulse)
   );

   // Reference model: an input level is accepted once the last DEB synchronised
   // samples since the previous flip/reset all disagree with the accepted level.
   int unsigned cyc = 0;
   bit [N-1:0]  m_s1 = '0, m_s2 = '0, m_lvl = '0, exp_pulse = '0;
   bit          hist[N][$];
`ifdef MULTI_PULSE_AUTO_REPEAT_EN
   bit          armed[N];
   int unsigned t_rise[N];
`endif

   task automatic model_step();
      cyc++;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; exp_pulse = '0;
         for (int ch = 0; ch < N; ch++) begin
            hist[ch].delete();
`ifdef MULTI_PULSE_AUTO_REPEAT_EN
            armed[ch] = 1'b0;
`endif
         end
      end else begin
         for (int ch = 0; ch < N; ch++) begin
            logic [1:0] md;
            bit all_diff, rise, p;
            md = edge_mode[2*ch +: 2];
            hist[ch].push_back(m_s2[ch]);
            if (hist[ch].size() > DEB) void'(hist[ch].pop_front());
            all_diff = (hist[ch].size() == DEB);
            for (int k = 0; k < hist[ch].size(); k++)
               if (hist[ch][k] == m_lvl[ch]) all_diff = 1'b0;
            rise = all_diff && !m_lvl[ch];
            p = 1'b0;
            if (all_diff) begin
               m_lvl[ch] = ~m_lvl[ch];
               hist[ch].delete();
               case (md)
                  2'b00:   p = rise;
                  2'b01:   p = !rise;
                  2'b10:   p = 1'b1;
                  default: p = 1'b0;
               endcase
            end
`ifdef MULTI_PULSE_AUTO_REPEAT_EN
            if (md == 2'b01 || md == 2'b11 || (all_diff && !rise)) armed[ch] = 1'b0;
            if (armed[ch]) begin
               int unsigned d;
               d = cyc - t_rise[ch];
               if (d == RD || (d > RD && (d - RD) % RP == 0)) p = 1'b1;
            end
            if (rise && (md == 2'b00 || md == 2'b10)) begin
               armed[ch]  = 1'b1;
               t_rise[ch] = cyc;
            end
`endif
            exp_pulse[ch] = p;
         end
         m_s2 = m_s1;
         m_s1 = in_trig;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_trig = 4'hF; edge_mode = '0;
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++;
         if (deb_level !== 4'h0 || out_pulse !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: deb_level=%b out_pulse=%b, expected 0000/0000", deb_level, out_pulse);
         end
      end
      rst = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         checks++;
         if (out_pulse !== ((j == 6) ? 4'hF : 4'h0) || deb_level !== ((j >= 6) ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL reset_release j=%0d: pulse=%b level=%b, expected pulse=%b level=%b",
                     j, out_pulse, deb_level, (j == 6) ? 4'hF : 4'h0, (j >= 6) ? 4'hF : 4'h0);
         end
      end
   endtask

   task automatic test_clean_rise();
      in_trig = 4'h0;
      for (int j = 0; j < 10; j++) begin
         tick();
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL rise_settle: pulse=%b level=%b, model %b/%b", out_pulse, deb_level, exp_pulse, m_lvl);
         end
      end
      in_trig[0] = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         checks++;
         if (out_pulse[0] !== (j == 6) || deb_level[0] !== (j >= 6)) begin
            errors++;
            $display("FAIL clean_rise j=%0d: pulse0=%b level0=%b, expected %b/%b",
                     j, out_pulse[0], deb_level[0], (j == 6), (j >= 6));
         end
      end
      in_trig[0] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL rise_release: pulse=%b level=%b, model %b/%b", out_pulse, deb_level, exp_pulse, m_lvl);
         end
      end
   endtask

   task automatic test_glitch();
      int pulses;
      pulses = 0;
      in_trig[1] = 1'b1;
      for (int j = 0; j < 13; j++) begin
         if (j == 3) in_trig[1] = 1'b0;
         tick();
         pulses += int'(out_pulse[1]);
         checks++;
         if (deb_level[1] !== 1'b0 || out_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL glitch_short: level1=%b pulse=%b, expected level1=0 pulse=%b", deb_level[1], out_pulse, exp_pulse);
         end
      end
      in_trig[1] = 1'b1;
      for (int j = 0; j < 16; j++) begin
         if (j == 4) in_trig[1] = 1'b0;
         tick();
         pulses += int'(out_pulse[1]);
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL glitch_long: pulse=%b level=%b, model %b/%b", out_pulse, deb_level, exp_pulse, m_lvl);
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL glitch_count: ch1 pulses=%0d, expected 1", pulses);
      end
   endtask

   task automatic test_modes();
      int cnt[N];
      int want[N];
      int reps;
      reps = 0;
`ifdef MULTI_PULSE_AUTO_REPEAT_EN
      // Fall is accepted 20 cycles after the rise pulse and cancels repeats from then on.
      for (int off = RD; off < 20; off += RP) reps++;
`endif
      want = '{1 + reps, 1, 2 + reps, 0};
      for (int ch = 0; ch < N; ch++) cnt[ch] = 0;
      edge_mode = {2'b11, 2'b10, 2'b01, 2'b00};
      for (int j = 0; j < 40; j++) begin
         in_trig = (j < 20) ? 4'hF : 4'h0;
         tick();
         for (int ch = 0; ch < N; ch++) cnt[ch] += int'(out_pulse[ch]);
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL modes_cycle j=%0d: pulse=%b level=%b, model %b/%b", j, out_pulse, deb_level, exp_pulse, m_lvl);
         end
         if (j == 19) begin
            checks++;
            if (deb_level !== 4'hF) begin
               errors++;
               $display("FAIL modes_level_high: deb_level=%b, expected 1111", deb_level);
            end
         end
      end
      checks++;
      if (deb_level !== 4'h0) begin
         errors++;
         $display("FAIL modes_level_low: deb_level=%b, expected 0000", deb_level);
      end
      for (int ch = 0; ch < N; ch++) begin
         checks++;
         if (cnt[ch] != want[ch]) begin
            errors++;
            $display("FAIL modes_count ch%0d: pulses=%0d, expected %0d", ch, cnt[ch], want[ch]);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit found;
      found = 1'b0;
      edge_mode = '0;
      in_trig = 4'hF;
      for (int j = 0; j < 12 && !found; j++) begin
         tick();
         if (out_pulse !== 4'h0) begin
            found = 1'b1;
            checks++;
            if (out_pulse !== 4'hF) begin
               errors++;
               $display("FAIL simultaneous: out_pulse=%b, expected 1111", out_pulse);
            end
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL simultaneous_timeout: out_pulse=%b, expected 1111 within 12 cycles", out_pulse);
      end
      in_trig = 4'h0;
      for (int j = 0; j < 12; j++) tick();
   endtask

   task automatic test_reset_mid();
      in_trig = 4'hF;
      for (int j = 0; j < 3; j++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         tick();
         checks++;
         if (out_pulse !== ((j == 6) ? 4'hF : 4'h0) || out_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL reset_mid j=%0d: out_pulse=%b, expected %b", j, out_pulse, (j == 6) ? 4'hF : 4'h0);
         end
      end
      in_trig = 4'h0;
      for (int j = 0; j < 10; j++) tick();
   endtask

   task automatic test_auto_repeat();
      logic [63:0] seen, want;
      seen = '0;
      want = 64'd1 << 6;
`ifdef MULTI_PULSE_AUTO_REPEAT_EN
      // Input released after 30 cycles: fall accepted at t0+30, so repeats stop before that.
      for (int off = RD; off < 30; off += RP) want |= 64'd1 << (6 + off);
`endif
      edge_mode = '0;
      in_trig[2] = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         if (j == 31) in_trig[2] = 1'b0;
         tick();
         if (out_pulse[2]) seen[j] = 1'b1;
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL repeat_cycle j=%0d: pulse=%b level=%b, model %b/%b", j, out_pulse, deb_level, exp_pulse, m_lvl);
         end
      end
      checks++;
      if (seen !== want) begin
         errors++;
         $display("FAIL repeat_pattern: ch2 pulse ticks=%h, expected %h", seen, want);
      end
   endtask

   task automatic test_random();
      int slow;
      slow = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) slow = $urandom_range(0, 1);
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(0, slow ? 39 : 6) == 0) in_trig[ch] = ~in_trig[ch];
         if ($urandom_range(0, 79) == 0) edge_mode = 8'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if (out_pulse !== exp_pulse || deb_level !== m_lvl) begin
            errors++;
            $display("FAIL random c=%0d: pulse=%b level=%b, model %b/%b", c, out_pulse, deb_level, exp_pulse, m_lvl);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_trig = '0;
      edge_mode = '0;
      test_reset();
      test_clean_rise();
      test_glitch();
      test_modes();
      test_simultaneous();
      test_reset_mid();
      test_auto_repeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
